// File: rtl/barrett_pkg.sv
// Shared types and default widths for the Barrett reduction engine.
// Modules derive their own widths from N; these mirror the default N=16.
package barrett_pkg;

    localparam int DEF_N = 16;
    localparam int W_AB  = 2 * DEF_N;
    localparam int W_MU  = DEF_N + 1;
    localparam int W_RR  = DEF_N + 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL_Q,
        MUL_QS,
        CORR1,
        CORR2,
        DONE
    } state_e;

endpackage

// File: rtl/barrett_reduce_cond_sub.sv
// Conditional subtract: out = (in >= s) ? in - s : in, on the N+2 bit remainder.
module cond_sub #(
    parameter int N = 16
) (
    input  logic [N+1:0] in_i,
    input  logic [N-1:0] s_i,
    output logic [N+1:0] out_o
);

    logic [N+1:0] s_ext;

    assign s_ext = {2'b00, s_i};
    assign out_o = (in_i >= s_ext) ? (in_i - s_ext) : in_i;

endmodule

// File: rtl/barrett_reduce.sv
// Iterative Barrett reduction r = ab mod s with one shared multiplier.
// Fixed 5-cycle latency from input handshake to out_valid; single job in flight.
module barrett_reduce
    import barrett_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [N-1:0]      s_i,
    input  logic [N:0]        mu_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2*N-1:0]    ab_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [N-1:0]      r_o,
    output logic              busy_o
);

    localparam int LW_AB = 2 * N;
    localparam int LW_MU = N + 1;
    localparam int LW_RR = N + 2;
    localparam int LW_P  = 2 * N + 2;

    state_e             state_q, state_d;
    logic [LW_AB-1:0]   ab_q, ab_d;
    logic [N-1:0]       s_q, s_d;
    logic [LW_MU-1:0]   mu_q, mu_d;
    logic [LW_MU-1:0]   q_q, q_d;
    logic [LW_RR-1:0]   rr_q, rr_d;

    logic [LW_MU-1:0]   t1;
    logic [LW_RR-1:0]   mul_a;
    logic [LW_MU-1:0]   mul_b;
    logic [LW_P-1:0]    prod;
    logic [LW_RR-1:0]   sub_out;

    // One multiplier: t1*mu in MUL_Q, q*s in MUL_QS. The top product bit
    // is never needed, so the product is kept at 2N+2 bits.
    assign t1    = ab_q[LW_AB-1:N-1];
    assign mul_a = (state_q == MUL_Q) ? LW_RR'(t1) : LW_RR'(s_q);
    assign mul_b = (state_q == MUL_Q) ? mu_q : q_q;
    assign prod  = LW_P'(mul_a) * LW_P'(mul_b);

    cond_sub #(.N(N)) u_cond_sub (
        .in_i  (rr_q),
        .s_i   (s_q),
        .out_o (sub_out)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ab_q    <= '0;
            s_q     <= '0;
            mu_q    <= '0;
            q_q     <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            s_q     <= s_d;
            mu_q    <= mu_d;
            q_q     <= q_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        s_d     = s_q;
        mu_d    = mu_q;
        q_d     = q_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    ab_d    = ab_i;
                    s_d     = s_i;
                    mu_d    = mu_i;
                    state_d = MUL_Q;
                end
            end
            MUL_Q: begin
                q_d     = prod[2*N+1:N+1];
                state_d = MUL_QS;
            end
            MUL_QS: begin
                // Wraps mod 2^(N+2); a valid s/mu pair keeps the result in [0, 3s).
                rr_d    = ab_q[LW_RR-1:0] - prod[LW_RR-1:0];
                state_d = CORR1;
            end
            CORR1: begin
                rr_d    = sub_out;
                state_d = CORR2;
            end
            CORR2: begin
                rr_d    = sub_out;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == IDLE) && reset_i;
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);
    assign r_o         = out_valid_o ? rr_q[N-1:0] : '0;

endmodule

// File: tb/tb_barrett_reduce.sv
// Bench for barrett_reduce: directed N=8 vectors and corner sequences,
// plus randomized N=16 jobs against a plain modulo reference.
module tb_barrett_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  s8 = 8'd251;
    logic [8:0]  mu8 = 9'd261;
    logic        iv8 = 1'b0, ir8, ov8, bz8;
    logic        or8 = 1'b0;
    logic [15:0] ab8 = '0;
    logic [7:0]  r8;

    logic [15:0] s16 = 16'd65521;
    logic [16:0] mu16 = 17'd65551;
    logic        iv16 = 1'b0, ir16, ov16, bz16;
    logic        or16 = 1'b0;
    logic [31:0] ab16 = '0;
    logic [15:0] r16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    barrett_reduce #(.N(8)) u8 (
        .clk_i(clk), .reset_i(rst), .s_i(s8), .mu_i(mu8),
        .in_valid_i(iv8), .in_ready_o(ir8), .ab_i(ab8),
        .out_valid_o(ov8), .out_ready_i(or8), .r_o(r8), .busy_o(bz8)
    );

    barrett_reduce #(.N(16)) u16 (
        .clk_i(clk), .reset_i(rst), .s_i(s16), .mu_i(mu16),
        .in_valid_i(iv16), .in_ready_o(ir16), .ab_i(ab16),
        .out_valid_o(ov16), .out_ready_i(or16), .r_o(r16), .busy_o(bz16)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Called at a negedge with the N=8 engine idle; returns at the negedge
    // where out_valid is seen (or the bound expires).
    task automatic job8(input logic [15:0] a, output int lat, output logic [7:0] res);
        ab8 = a;
        iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = r8;
    endtask

    task automatic job16(input logic [31:0] a, output int lat, output logic [15:0] res);
        ab16 = a;
        iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = r16;
    endtask

    typedef struct {
        logic [15:0] ab;
        logic [7:0]  r;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          lat;
        logic [7:0]  res8;
        logic [15:0] res16;
        int          hs_t[2];
        int          out_t[2];
        logic [7:0]  out_v[2];
        int          nhs, nout;
        logic [31:0] a32;
        logic [63:0] ref_r;
        logic [31:0] edge_ab[5];

        tbl[0] = '{16'd62500, 8'd1};
        tbl[1] = '{16'd0,     8'd0};
        tbl[2] = '{16'd250,   8'd250};
        tbl[3] = '{16'd251,   8'd0};
        tbl[4] = '{16'd502,   8'd0};
        tbl[5] = '{16'd65000, 8'd242};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ov8", ov8, 0);
        chk("rst_r8", r8, 0);
        chk("rst_ir8", ir8, 0);
        chk("rst_bz8", bz8, 0);
        chk("rst_ov16", ov16, 0);
        chk("rst_bz16", bz16, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ir8", ir8, 1);
        chk("post_rst_ir16", ir16, 1);

        // Directed vectors at fixed latency
        foreach (tbl[i]) begin
            job8(tbl[i].ab, lat, res8);
            chk($sformatf("vec%0d_lat", i), lat, 5);
            chk($sformatf("vec%0d_r", i), res8, tbl[i].r);
            or8 = 1'b1;
            @(negedge clk);
            or8 = 1'b0;
            chk($sformatf("vec%0d_ov_drop", i), ov8, 0);
            chk($sformatf("vec%0d_ir_back", i), ir8, 1);
        end

        // Back-pressure: result must hold while out_ready is low
        job8(16'd62500, lat, res8);
        chk("bp_lat", lat, 5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_ov", ov8, 1);
            chk("bp_r", r8, 1);
            chk("bp_ir", ir8, 0);
            chk("bp_busy", bz8, 1);
            @(negedge clk);
        end
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("bp_release_ov", ov8, 0);
        chk("bp_release_ir", ir8, 1);

        // Reset during CORR1 abandons the job
        ab8 = 16'd62500;
        iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ov", ov8, 0);
        chk("midrst_busy", bz8, 0);
        chk("midrst_r", r8, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ir", ir8, 1);
        chk("midrst_busy2", bz8, 0);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_stale", ov8, 0);
            @(negedge clk);
        end

        // Back-to-back with in_valid held high
        nhs = 0;
        nout = 0;
        ab8 = 16'd62500;
        iv8 = 1'b1;
        or8 = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (ov8 && nout < 2) begin
                out_t[nout] = cyc;
                out_v[nout] = r8;
                nout++;
            end
            if (ir8 && iv8 && nhs < 2) begin
                hs_t[nhs] = cyc;
                nhs++;
            end else if (nhs == 1) begin
                ab8 = 16'd65000;
            end else if (nhs == 2) begin
                iv8 = 1'b0;
            end
            @(negedge clk);
        end
        or8 = 1'b0;
        iv8 = 1'b0;
        chk("b2b_nhs", nhs, 2);
        chk("b2b_nout", nout, 2);
        if (nhs == 2 && nout == 2) begin
            chk("b2b_r0", out_v[0], 1);
            chk("b2b_r1", out_v[1], 242);
            chk("b2b_lat0", out_t[0] - hs_t[0], 5);
            chk("b2b_ii_in", hs_t[1] - hs_t[0], 6);
            chk("b2b_ii_out", out_t[1] - out_t[0], 6);
        end

        // N=16 edge cases then random jobs against ab mod s
        edge_ab[0] = 32'd0;
        edge_ab[1] = 32'd65520;
        edge_ab[2] = 32'd65521;
        edge_ab[3] = 32'hFFFF_FFFF;
        edge_ab[4] = 32'd65521 * 32'd65535;
        for (int i = 0; i < 1000; i++) begin
            a32 = (i < 5) ? edge_ab[i] : $urandom;
            ref_r = 64'(a32) % 64'd65521;
            job16(a32, lat, res16);
            chk("rnd_lat", lat, 5);
            chk("rnd_r", res16, ref_r);
            or16 = 1'b1;
            @(negedge clk);
            or16 = 1'b0;
            chk("rnd_ir_back", ir16, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/barrett_reduce.md
Name: barrett_reduce

Overview:
- Downstream stage of the modular multiplier: consumes the raw 2N-bit product ab = a*b and produces r = ab mod s by Barrett reduction.
- Iterative, single-entry engine with one shared (N+2)x(N+1) multiplier, reused across states.
- Valid/ready handshake on input and output, so it can be back-pressured by the MSM accumulator.

Parameters:
- N, 16, bit width of field elements; modulus s must satisfy 2^(N-1) < s < 2^N.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- s  in  N  modulus; sampled on input handshake
- mu  in  N+1  Barrett constant floor(2^(2N)/s); sampled on input handshake
- in_valid  in  1  ab/s/mu valid
- in_ready  out  1  block can accept (high only in IDLE)
- ab  in  2N  product to reduce; sampled on input handshake
- out_valid  out  1  r valid
- out_ready  in  1  consumer accepts r
- r  out  N  reduced result, 0 <= r < s
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; out_valid=0, r=0, in_ready=0 during the reset cycle, busy=0; all internal registers cleared. Reset mid-operation abandons the job; no output is produced.
- States: IDLE -> MUL_Q -> MUL_QS -> CORR1 -> CORR2 -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch ab, s, mu; go to MUL_Q.
- MUL_Q: t1 = ab[2N-1:N-1] (N+1 bits); q = (t1*mu) >> (N+1), truncated to N+1 bits; register q.
- MUL_QS: rr = (ab - q*s) mod 2^(N+2), computed in N+2 bits; register rr. Guaranteed 0 <= rr < 3s.
- CORR1: if rr >= s then rr <= rr - s.
- CORR2: if rr >= s then rr <= rr - s. Both correction states are always traversed, giving fixed latency.
- DONE: out_valid=1, r=rr[N-1:0]. r and out_valid hold stable until out_ready=1.
  - On the handshake, go to IDLE.
  - in_ready rises the cycle after the output handshake; there is no overlap.
- Latency: input handshake at cycle 0 -> out_valid high at cycle 5. Minimum initiation interval: 6 cycles.
- in_valid while busy is ignored; input fields may change freely while busy.
- Precondition violations (s out of range, or mu not matching s) give an unspecified r. The FSM must still complete and return to IDLE.
- ab=0 -> r=0. ab<s -> r=ab. ab=k*s -> r=0.

Decomposition:
- Shared package barrett_pkg holds:
  - state enum (IDLE, MUL_Q, MUL_QS, CORR1, CORR2, DONE)
  - localparams for widths: W_AB=2N, W_MU=N+1, W_RR=N+2.
- One natural sub-module: cond_sub (N+2 bits in, s in, outputs in>=s ? in-s : in). Instantiated once and shared by CORR1/CORR2.
- The multiplier stays inline in the parent.

Test Plan:
- N=8, s=251, mu=261, ab=62500 (250*250):
  - q=248, rr=252 after MUL_QS, one correction.
  - out_valid at cycle 5, r=1.
- N=8, s=251, mu=261, ab=0 -> r=0; ab=250 -> r=250; ab=251 -> r=0; ab=502 -> r=0. Each at fixed latency 5.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> r stable at 1, in_ready=0, busy=1. Then out_ready=1 for one cycle -> next cycle out_valid=0, in_ready=1.
- Reset mid-job: assert reset=0 during CORR1 -> next cycle out_valid=0, busy=0, in_ready=1 after reset release. No stale output afterwards.
- Back-to-back: in_valid held high with ab=62500 then ab=65000 (r=65000 mod 251=242) and out_ready=1 -> outputs 1 then 242, initiation interval exactly 6 cycles.
- Random: N=16, s=65521, mu=65551, 1000 random ab < 2^32 -> r equals ab mod 65521 against a reference model.
